// File: rtl/alu_seq_if.sv
// Main-bus bundle between the sequenced ALU (master) and the bus side (slave).
// Carries the operand fetch / result write handshake and the tri-state enables.
interface alu_seq_if #(
  parameter int W = 4
);
  logic [W-1:0] bus_in;
  logic         bus_ready;
  logic [3:0]   bus_req;
  logic [W-1:0] bus_out;
  logic [W-1:0] bus_oe;

  modport master (
    input  bus_in,
    input  bus_ready,
    output bus_req,
    output bus_out,
    output bus_oe
  );

  modport slave (
    output bus_in,
    output bus_ready,
    input  bus_req,
    input  bus_out,
    input  bus_oe
  );
endinterface

// File: rtl/alu_seq.sv
// W-bit sequenced ALU: latches opcode/imm on start, fetches operand B over the
// main bus, computes one of seven operations and writes the result back.
module alu_seq #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   opcode,
  input  logic [W-1:0] imm,
  alu_seq_if.master    bus,
  output logic         busy,
  output logic         done,
  output logic         carry,
  output logic         zero,
  output logic         err
);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;

  localparam logic [3:0] REQ_NONE  = 4'b0000;
  localparam logic [3:0] REQ_OPND  = 4'b0011;
  localparam logic [3:0] REQ_READ  = 4'b0001;
  localparam logic [3:0] REQ_WRITE = 4'b0010;

  // W always fits in W bits for W >= 2, so the shift-range test stays W wide.
  localparam logic [W-1:0] W_L = W'(W);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_FETCH = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  state_e       state_q;
  logic [3:0]   op_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [3:0]   req_q;
  logic [W-1:0] out_q;
  logic [W-1:0] oe_q;
  logic         busy_q;
  logic         done_q;
  logic         carry_q;
  logic         zero_q;
  logic         err_q;

  logic [W:0]   sum_d;
  logic [W:0]   diff_d;
  logic [W-1:0] res_d;
  logic         carry_d;
  logic         shift_big_d;

  assign sum_d       = {1'b0, a_q} + {1'b0, b_q};
  assign diff_d      = {1'b0, a_q} - {1'b0, b_q};
  assign shift_big_d = (a_q >= W_L);

  // Result and carry of the latched operation, consumed in EXEC.
  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_d   = sum_d[W-1:0];
        carry_d = sum_d[W];
      end
      OP_SUB: begin
        res_d   = diff_d[W-1:0];
        carry_d = diff_d[W];
      end
      OP_AND: res_d = a_q & b_q;
      OP_OR:  res_d = a_q | b_q;
      OP_XOR: res_d = a_q ^ b_q;
      OP_SHL: begin
        if (shift_big_d) begin
          res_d = '0;
        end else begin
          res_d = b_q << a_q;
        end
      end
      OP_SHR: begin
        if (shift_big_d) begin
          res_d = '0;
        end else begin
          res_d = b_q >> a_q;
        end
      end
      default: begin
        res_d   = '0;
        carry_d = 1'b0;
      end
    endcase
  end

  // Sequencer; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= 4'd0;
      a_q     <= '0;
      b_q     <= '0;
      req_q   <= REQ_NONE;
      out_q   <= '0;
      oe_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q   <= opcode;
            a_q    <= imm;
            busy_q <= 1'b1;
            if ((opcode == OP_NOP) || opcode[3]) begin
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_REQ;
              req_q   <= REQ_OPND;
            end
          end
        end
        ST_REQ: begin
          if (bus.bus_ready) begin
            state_q <= ST_FETCH;
            req_q   <= REQ_READ;
          end
        end
        ST_FETCH: begin
          if (bus.bus_ready) begin
            b_q     <= bus.bus_in;
            state_q <= ST_EXEC;
            req_q   <= REQ_NONE;
          end
        end
        ST_EXEC: begin
          carry_q <= carry_d;
          zero_q  <= (res_d == '0);
          out_q   <= res_d;
          oe_q    <= '1;
          req_q   <= REQ_WRITE;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          if (bus.bus_ready) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            out_q   <= '0;
            oe_q    <= '0;
            req_q   <= REQ_NONE;
          end
        end
        // NOP and illegal opcodes complete without touching the bus or flags.
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          err_q   <= op_q[3];
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          out_q   <= '0;
          oe_q    <= '0;
          req_q   <= REQ_NONE;
        end
      endcase
    end
  end

  assign bus.bus_req = req_q;
  assign bus.bus_out = out_q;
  assign bus.bus_oe  = oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign carry       = carry_q;
  assign zero        = zero_q;
  assign err         = err_q;

endmodule
